// File: rtl/driver_interface_mc_if.sv
`timescale 1ns/1ps
// Bus and stream bundle for driver_interface_mc.
// master = software/stream side, slave = bridge side.
// Carries the register bus strobes/data, per-channel sample streams and the interrupt.
interface driver_interface_mc_if #(
  parameter int DATA_SIZE = 28,
  parameter int CHANNELS  = 2
);
  logic                          chipselect;
  logic [3:0]                    address;
  logic                          read;
  logic                          write;
  logic [31:0]                   write_data;
  logic [31:0]                   read_data;
  logic [CHANNELS-1:0]           source_valid;
  logic [CHANNELS*DATA_SIZE-1:0] source_data;
  logic [CHANNELS-1:0]           source_ready;
  logic                          irq;

  modport master (
    output chipselect, address, read, write, write_data, source_valid, source_data,
    input  read_data, source_ready, irq
  );

  modport slave (
    input  chipselect, address, read, write, write_data, source_valid, source_data,
    output read_data, source_ready, irq
  );
endinterface

// File: rtl/driver_interface_mc.sv
`timescale 1ns/1ps
// Multi-channel stream-to-bus bridge: one FIFO per channel, register-mapped reads, level/overflow irq.
// Latency: read_data valid one cycle after the bus strobe; irq follows its condition by one cycle.
// Backpressure: source_ready[k] drops combinationally while FIFO k is full; pushes while full are dropped and flagged.
//
// Ports: clk, rst_n (async active-low), bus (driver_interface_mc_if.slave):
//   chipselect/address/read/write/write_data/read_data - register bus, read_data registered
//   source_valid/source_data/source_ready             - per-channel sample streams
//   irq                                               - registered level-high interrupt
// Register map: 0x0-0x3 DATA k (pop), 0x4 STATUS (W1C ovf at [19:16]), 0x5 CONTROL, 0x8-0xB LEVEL k.
module driver_interface_mc #(
  parameter int DATA_SIZE  = 28,
  parameter int DEPTH      = 2048,
  parameter int CHANNELS   = 2,
  parameter int IRQ_THRESH = DEPTH / 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  driver_interface_mc_if.slave bus
);

  localparam int LW = ADDR_WIDTH + 1;

  logic                          rd_en;
  logic                          wr_en;
  logic                          ovf_clr_wr;
  logic [CHANNELS-1:0]           empty;
  logic [CHANNELS-1:0]           full;
  logic [CHANNELS-1:0]           push;
  logic [CHANNELS-1:0]           pop;
  logic [CHANNELS-1:0]           ovf;
  logic [CHANNELS*LW-1:0]        cnt_flat;
  logic [CHANNELS*DATA_SIZE-1:0] head_flat;

  logic                          irq_en;
  logic [LW-1:0]                 thr;
  logic                          irq_q;
  logic                          irq_next;
  logic [31:0]                   rd_q;
  logic [31:0]                   rd_mux;
  logic [31:0]                   status;
  logic [31:0]                   control;

  assign rd_en      = bus.chipselect & bus.read;
  assign wr_en      = bus.chipselect & bus.write;
  assign ovf_clr_wr = wr_en & (bus.address == 4'h4);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]         cnt;
    logic                  ovf_q;

    assign empty[g] = (cnt == '0);
    assign full[g]  = (cnt == LW'(DEPTH));
    // full is taken from the pre-edge count, so a pop in the same cycle cannot rescue a push.
    assign push[g]  = bus.source_valid[g] & ~full[g];
    assign pop[g]   = rd_en & (bus.address == 4'(g)) & ~empty[g];
    assign ovf[g]   = ovf_q;

    assign cnt_flat[g*LW +: LW]               = cnt;
    // Asynchronous head read so a word written at edge N is poppable at edge N+1.
    assign head_flat[g*DATA_SIZE +: DATA_SIZE] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem[wr_ptr] <= bus.source_data[g*DATA_SIZE +: DATA_SIZE];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
        // A fresh overflow beats a simultaneous write-1-to-clear.
        if (bus.source_valid[g] && full[g]) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr_wr && bus.write_data[16+g]) begin
          ovf_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    status     = '0;
    status[24] = irq_q;
    for (int k = 0; k < CHANNELS; k++) begin
      status[k]    = empty[k];
      status[8+k]  = full[k];
      status[16+k] = ovf[k];
    end
  end

  always_comb begin
    control          = '0;
    control[0]       = irq_en;
    control[16 +: LW] = thr;
  end

  // Unmapped addresses and channel indices beyond CHANNELS fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.address == 4'(k) && !empty[k]) begin
        rd_mux = 32'(head_flat[k*DATA_SIZE +: DATA_SIZE]);
      end
      if (bus.address == 4'(8 + k)) begin
        rd_mux = 32'(cnt_flat[k*LW +: LW]);
      end
    end
    if (bus.address == 4'h4) rd_mux = status;
    if (bus.address == 4'h5) rd_mux = control;
  end

  always_comb begin
    irq_next = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if ((cnt_flat[k*LW +: LW] >= thr) || ovf[k]) irq_next = 1'b1;
    end
    irq_next = irq_next & irq_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      irq_q  <= 1'b0;
      irq_en <= 1'b0;
      thr    <= LW'(IRQ_THRESH);
    end else begin
      if (rd_en) rd_q <= rd_mux;
      irq_q <= irq_next;
      if (wr_en && bus.address == 4'h5) begin
        irq_en <= bus.write_data[0];
        thr    <= bus.write_data[16 +: LW];
      end
    end
  end

  assign bus.read_data    = rd_q;
  assign bus.irq          = irq_q;
  assign bus.source_ready = ~full;

endmodule

// File: tb/tb_driver_interface_mc.sv
`timescale 1ns/1ps
module tb_driver_interface_mc;

  localparam int DS    = 28;
  localparam int CH    = 2;
  localparam int DEPTH = 2048;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  driver_interface_mc_if #(.DATA_SIZE(DS), .CHANNELS(CH)) bus ();

  driver_interface_mc #(.DATA_SIZE(DS), .DEPTH(DEPTH), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_push(input int ch, input logic [31:0] v);
    if (ch == 0) begin
      if (q0.size() < DEPTH) q0.push_back(v);
    end else begin
      if (q1.size() < DEPTH) q1.push_back(v);
    end
  endfunction

  function automatic logic [31:0] model_pop(input int ch);
    logic [31:0] v;
    v = '0;
    if (ch == 0) begin
      if (q0.size() > 0) v = q0.pop_front();
    end else begin
      if (q1.size() > 0) v = q1.pop_front();
    end
    return v;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    @(posedge clk); #1;
    d              = bus.read_data;
    bus.read       = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] wd);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.write_data = wd;
    @(posedge clk); #1;
    bus.write      = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  task automatic rd_data(input int ch, input string name);
    logic [31:0] d;
    logic [31:0] e;
    e = model_pop(ch);
    bus_rd(4'(ch), d);
    chk(name, d, e);
  endtask

  task automatic push_one(input int ch, input logic [31:0] v);
    bus.source_valid[ch]          = 1'b1;
    bus.source_data[ch*DS +: DS]  = v[DS-1:0];
    @(posedge clk); #1;
    model_push(ch, v);
    bus.source_valid = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] v;
    checks = 0;
    errors = 0;
    bus.chipselect   = 1'b0;
    bus.address      = '0;
    bus.read         = 1'b0;
    bus.write        = 1'b0;
    bus.write_data   = '0;
    bus.source_valid = '0;
    bus.source_data  = '0;

    vt[0]  = '{0, 4'h4, 32'h0, 32'h0000_0003};
    vt[1]  = '{0, 4'h5, 32'h0, 32'h0400_0000};
    vt[2]  = '{0, 4'h8, 32'h0, 32'h0};
    vt[3]  = '{0, 4'h9, 32'h0, 32'h0};
    vt[4]  = '{0, 4'h0, 32'h0, 32'h0};
    vt[5]  = '{0, 4'h1, 32'h0, 32'h0};
    vt[6]  = '{0, 4'h2, 32'h0, 32'h0};
    vt[7]  = '{0, 4'h6, 32'h0, 32'h0};
    vt[8]  = '{1, 4'h5, 32'h0005_0001, 32'h0};
    vt[9]  = '{0, 4'h5, 32'h0, 32'h0005_0001};
    vt[10] = '{1, 4'h5, 32'h0400_0000, 32'h0};
    vt[11] = '{0, 4'h5, 32'h0, 32'h0400_0000};

    // Reset and defaults
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", bus.read_data, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    chk("rst_ready", 32'(bus.source_ready), 32'h3);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) begin
        bus_wr(vt[i].addr, vt[i].wdata);
      end else begin
        bus_rd(vt[i].addr, d);
        chk($sformatf("vec%0d", i), d, vt[i].exp);
      end
    end

    // Channel independence
    push_one(0, 32'hAAA1);
    push_one(0, 32'hAAA2);
    push_one(1, 32'hBBB1);
    rd_data(0, "ind_d0_a");
    rd_data(0, "ind_d0_b");
    rd_data(1, "ind_d1");
    rd_data(0, "ind_d0_empty");
    bus_rd(4'h8, d);
    chk("ind_level0", d, 32'h0);

    // Full and overflow on ch0
    for (int i = 0; i <= DEPTH; i++) begin
      push_one(0, 32'(i));
      if (i == DEPTH - 2) chk("ready_before_full", 32'(bus.source_ready), 32'h3);
      if (i == DEPTH - 1) chk("ready_at_full", 32'(bus.source_ready), 32'h2);
    end
    bus_rd(4'h4, d);
    chk("status_full_ovf", d, 32'h0001_0102);
    for (int i = 0; i < DEPTH; i++) rd_data(0, "full_drain");
    rd_data(0, "full_drain_empty");
    bus_rd(4'h4, d);
    chk("status_drained", d, 32'h0001_0003);
    bus_wr(4'h4, 32'h0001_0000);
    bus_rd(4'h4, d);
    chk("status_ovf_clr", d, 32'h0000_0003);

    // Wrap with simultaneous push and pop on ch1
    push_one(1, 32'h51);
    push_one(1, 32'h52);
    push_one(1, 32'h53);
    for (int i = 0; i < 5000; i++) begin
      v = 32'h100 + 32'(i);
      bus.source_valid[1]    = 1'b1;
      bus.source_data[DS +: DS] = v[DS-1:0];
      bus.chipselect         = 1'b1;
      bus.read               = 1'b1;
      bus.address            = 4'h1;
      e = model_pop(1);
      @(posedge clk); #1;
      model_push(1, v);
      chk("wrap_data", bus.read_data, e);
      if (i % 1000 == 999) begin
        bus.source_valid = '0;
        bus_rd(4'h9, d);
        chk("wrap_level1", d, 32'h3);
      end
    end
    bus.source_valid = '0;
    bus.read         = 1'b0;
    bus.chipselect   = 1'b0;
    bus_rd(4'h9, d);
    chk("wrap_level1_end", d, 32'h3);
    for (int i = 0; i < 3; i++) rd_data(1, "wrap_drain");

    // Level-threshold interrupt
    bus_wr(4'h5, 32'h0004_0001);
    for (int i = 0; i < 4; i++) push_one(1, 32'h61 + 32'(i));
    chk("irq_after_4th_push", 32'(bus.irq), 32'h0);
    @(posedge clk); #1;
    chk("irq_one_later", 32'(bus.irq), 32'h1);
    rd_data(1, "irq_pop");
    chk("irq_still_high", 32'(bus.irq), 32'h1);
    @(posedge clk); #1;
    chk("irq_dropped", 32'(bus.irq), 32'h0);
    for (int i = 0; i < 3; i++) rd_data(1, "irq_drain");

    // Overflow with irq disabled, then enabled with an unreachable level threshold
    bus_wr(4'h5, 32'h0004_0000);
    for (int i = 0; i <= DEPTH; i++) push_one(0, 32'h7000 + 32'(i));
    @(posedge clk); #1;
    chk("irq_disabled_a", 32'(bus.irq), 32'h0);
    @(posedge clk); #1;
    chk("irq_disabled_b", 32'(bus.irq), 32'h0);
    bus_rd(4'h4, d);
    chk("status_ovf_noirq", d, 32'h0001_0102);
    bus_wr(4'h5, 32'h0FFF_0001);
    chk("irq_ovf_pre", 32'(bus.irq), 32'h0);
    @(posedge clk); #1;
    chk("irq_ovf", 32'(bus.irq), 32'h1);
    bus_wr(4'h4, 32'h0001_0000);
    chk("irq_ovf_clr_edge", 32'(bus.irq), 32'h1);
    @(posedge clk); #1;
    chk("irq_ovf_cleared", 32'(bus.irq), 32'h0);

    // Reset discards a full FIFO
    #4 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_ready", 32'(bus.source_ready), 32'h3);

    // Async reset mid-stream with ch0 at level 10
    bus_wr(4'h5, 32'h0004_0001);
    for (int i = 0; i < 10; i++) push_one(0, 32'h900 + 32'(i));
    @(posedge clk); #1;
    chk("mid_irq_high", 32'(bus.irq), 32'h1);
    bus_rd(4'h5, d);
    chk("mid_control", d, 32'h0004_0001);
    bus_rd(4'h8, d);
    chk("mid_level0", d, 32'd10);
    #4 rst_n = 1'b0;
    #1;
    chk("mid_rst_read_data", bus.read_data, 32'h0);
    chk("mid_rst_irq", 32'(bus.irq), 32'h0);
    chk("mid_rst_ready", 32'(bus.source_ready), 32'h3);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rd(4'h8, d);
    chk("post_rst_level0", d, 32'h0);
    rd_data(0, "post_rst_d0");
    rd_data(1, "post_rst_d1");
    bus_rd(4'h5, d);
    chk("post_rst_control", d, 32'h0400_0000);
    bus_rd(4'h4, d);
    chk("post_rst_status", d, 32'h0000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
